// File: rtl/bfly_stage_fac8_1_if.sv
// Beat-level bus between the butterfly stage and its neighbours: two-beat complex
// input pairs in, 16-lane sum/difference arrays plus twiddle select out.
interface bfly_stage_fac8_1_if #(
   parameter int IN_WIDTH  = 10,
   parameter int OUT_WIDTH = 11,
   parameter int DEPTH     = 16,
   parameter int SEL_WIDTH = 3
);
   logic                                din_valid;
   logic                                din_sof;
   logic [DEPTH-1:0][IN_WIDTH-1:0]      din_R;
   logic [DEPTH-1:0][IN_WIDTH-1:0]      din_Q;
   logic                                dout_valid;
   logic [DEPTH-1:0][OUT_WIDTH-1:0]     dout_R_add;
   logic [DEPTH-1:0][OUT_WIDTH-1:0]     dout_R_sub;
   logic [DEPTH-1:0][OUT_WIDTH-1:0]     dout_Q_add;
   logic [DEPTH-1:0][OUT_WIDTH-1:0]     dout_Q_sub;
   logic [SEL_WIDTH-1:0]                select;
   logic                                sync_err;

   modport master (
      output din_valid, din_sof, din_R, din_Q,
      input  dout_valid, dout_R_add, dout_R_sub, dout_Q_add, dout_Q_sub, select, sync_err
   );

   modport slave (
      input  din_valid, din_sof, din_R, din_Q,
      output dout_valid, dout_R_add, dout_R_sub, dout_Q_add, dout_Q_sub, select, sync_err
   );
endinterface

// File: rtl/bfly_stage_fac8_1.sv
// Radix-2 butterfly feeding the factor-8 twiddle multiplier: pairs consecutive beats
// (x, y) into x+y / x-y per lane and tags each result with a frame-relative select.
module bfly_stage_fac8_1 #(
   parameter int IN_WIDTH  = 10,
   parameter int OUT_WIDTH = 11,
   parameter int DEPTH     = 16,
   parameter int SEL_WIDTH = 3
) (
   input  logic                clk,
   input  logic                rst,
   bfly_stage_fac8_1_if.slave  bus
);

   typedef enum logic [0:0] {S_FIRST, S_SECOND} state_t;

   state_t                          state;
   logic [SEL_WIDTH-1:0]            sel_cnt;
   logic [DEPTH-1:0][IN_WIDTH-1:0]  x_R;
   logic [DEPTH-1:0][IN_WIDTH-1:0]  x_Q;

   logic                            dout_valid_q;
   logic                            sync_err_q;
   logic [SEL_WIDTH-1:0]            select_q;
   logic [DEPTH-1:0][OUT_WIDTH-1:0] r_add_q, r_sub_q, q_add_q, q_sub_q;

   function automatic logic [OUT_WIDTH-1:0] sext(input logic [IN_WIDTH-1:0] v);
      sext = OUT_WIDTH'($signed(v));
   endfunction

   // NOTE: all state below uses non-blocking assignments so every register samples
   // pre-edge values; a blocking write to x_R would leak the new beat into this cycle's sums.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_FIRST;
         sel_cnt      <= '0;
         // NOTE: the x buffer is a plain register bank, not a RAM, so clearing it on
         // reset is cheap and keeps the pipeline free of stale operands.
         x_R          <= '0;
         x_Q          <= '0;
         dout_valid_q <= 1'b0;
         sync_err_q   <= 1'b0;
         select_q     <= '0;
         r_add_q      <= '0;
         r_sub_q      <= '0;
         q_add_q      <= '0;
         q_sub_q      <= '0;
      end else begin
         dout_valid_q <= 1'b0;
         sync_err_q   <= 1'b0;
         if (bus.din_valid) begin
            if (bus.din_sof) begin
               // Frame start always re-anchors the pair and the select sequence.
               x_R        <= bus.din_R;
               x_Q        <= bus.din_Q;
               sel_cnt    <= '0;
               sync_err_q <= (state == S_SECOND);
               state      <= S_SECOND;
            end else if (state == S_FIRST) begin
               x_R   <= bus.din_R;
               x_Q   <= bus.din_Q;
               state <= S_SECOND;
            end else begin
               for (int i = 0; i < DEPTH; i++) begin
                  r_add_q[i] <= sext(x_R[i]) + sext(bus.din_R[i]);
                  r_sub_q[i] <= sext(x_R[i]) - sext(bus.din_R[i]);
                  q_add_q[i] <= sext(x_Q[i]) + sext(bus.din_Q[i]);
                  q_sub_q[i] <= sext(x_Q[i]) - sext(bus.din_Q[i]);
               end
               dout_valid_q <= 1'b1;
               select_q     <= sel_cnt;
               sel_cnt      <= sel_cnt + 1'b1;
               state        <= S_FIRST;
            end
         end
      end
   end

   assign bus.dout_valid = dout_valid_q;
   assign bus.sync_err   = sync_err_q;
   assign bus.select     = select_q;
   assign bus.dout_R_add = r_add_q;
   assign bus.dout_R_sub = r_sub_q;
   assign bus.dout_Q_add = q_add_q;
   assign bus.dout_Q_sub = q_sub_q;

endmodule

// File: tb/tb_bfly_stage_fac8_1.sv
// Self-checking bench for bfly_stage_fac8_1: directed plan items plus randomized traffic
// compared every cycle against an integer-arithmetic pairing model.
module tb_bfly_stage_fac8_1;
   localparam int IN_WIDTH  = 10;
   localparam int OUT_WIDTH = 11;
   localparam int DEPTH     = 16;
   localparam int SEL_WIDTH = 3;
   localparam int AW        = DEPTH * OUT_WIDTH;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bfly_stage_fac8_1_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .DEPTH(DEPTH),
                          .SEL_WIDTH(SEL_WIDTH)) bus ();

   bfly_stage_fac8_1 #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .DEPTH(DEPTH),
                       .SEL_WIDTH(SEL_WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_pass   = 0;

   // Stimulus for the current beat.
   int cur_r[DEPTH];
   int cur_q[DEPTH];

   // Behavioural model: a pending first beat (or none) and a running pair counter.
   bit have_x;
   int xr[DEPTH], xq[DEPTH];
   int pair_cnt;
   int m_ra[DEPTH], m_rs[DEPTH], m_qa[DEPTH], m_qs[DEPTH];
   bit m_valid, m_err;
   int m_sel;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   function automatic logic [AW-1:0] pack_lanes(input int v[DEPTH]);
      logic [DEPTH-1:0][OUT_WIDTH-1:0] p;
      for (int i = 0; i < DEPTH; i++) p[i] = OUT_WIDTH'(v[i]);
      return p;
   endfunction

   function automatic logic [AW-1:0] rep(input int v);
      logic [DEPTH-1:0][OUT_WIDTH-1:0] p;
      for (int i = 0; i < DEPTH; i++) p[i] = OUT_WIDTH'(v);
      return p;
   endfunction

   task automatic model_update(input bit v, input bit s, input bit r);
      if (r) begin
         have_x = 0; pair_cnt = 0; m_valid = 0; m_err = 0; m_sel = 0;
         for (int i = 0; i < DEPTH; i++) begin
            xr[i] = 0; xq[i] = 0; m_ra[i] = 0; m_rs[i] = 0; m_qa[i] = 0; m_qs[i] = 0;
         end
         return;
      end
      m_valid = 0;
      m_err   = 0;
      if (!v) return;
      if (s || !have_x) begin
         if (s) begin
            m_err    = have_x;
            pair_cnt = 0;
         end
         have_x = 1;
         xr = cur_r;
         xq = cur_q;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            m_ra[i] = xr[i] + cur_r[i];
            m_rs[i] = xr[i] - cur_r[i];
            m_qa[i] = xq[i] + cur_q[i];
            m_qs[i] = xq[i] - cur_q[i];
         end
         m_valid  = 1;
         m_sel    = pair_cnt % (1 << SEL_WIDTH);
         pair_cnt = pair_cnt + 1;
         have_x   = 0;
      end
   endtask

   task automatic compare_all();
      check("dout_valid", 256'(bus.dout_valid), 256'(m_valid));
      check("sync_err",   256'(bus.sync_err),   256'(m_err));
      check("select",     256'(bus.select),     256'(m_sel));
      check("R_add",      256'(bus.dout_R_add), 256'(pack_lanes(m_ra)));
      check("R_sub",      256'(bus.dout_R_sub), 256'(pack_lanes(m_rs)));
      check("Q_add",      256'(bus.dout_Q_add), 256'(pack_lanes(m_qa)));
      check("Q_sub",      256'(bus.dout_Q_sub), 256'(pack_lanes(m_qs)));
   endtask

   // Apply one cycle of inputs (at the falling edge), advance the model, compare after the edge.
   task automatic step(input bit v, input bit s, input bit r);
      bus.din_valid = v;
      bus.din_sof   = s;
      rst           = r;
      for (int i = 0; i < DEPTH; i++) begin
         bus.din_R[i] = IN_WIDTH'(cur_r[i]);
         bus.din_Q[i] = IN_WIDTH'(cur_q[i]);
      end
      model_update(v, s, r);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic fill_const(input int rv, input int qv);
      for (int i = 0; i < DEPTH; i++) begin
         cur_r[i] = rv; cur_q[i] = qv;
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < DEPTH; i++) begin
         cur_r[i] = int'($urandom_range(1023)) - 512;
         cur_q[i] = int'($urandom_range(1023)) - 512;
      end
   endtask

   int pulses;

   initial begin
      bus.din_valid = 1'b0;
      bus.din_sof   = 1'b0;
      bus.din_R     = '0;
      bus.din_Q     = '0;
      fill_const(0, 0);
      @(negedge clk);
      step(0, 0, 1);
      step(0, 0, 1);
      check("reset_valid", 256'(bus.dout_valid), 256'(0));
      check("reset_R_add", 256'(bus.dout_R_add), 256'(rep(0)));

      // Basic pair.
      fill_const(100, -50); step(1, 0, 0);
      fill_const(20, 30);   step(1, 0, 0);
      check("lit_valid", 256'(bus.dout_valid), 256'(1));
      check("lit_R_add", 256'(bus.dout_R_add), 256'(rep(120)));
      check("lit_R_sub", 256'(bus.dout_R_sub), 256'(rep(80)));
      check("lit_Q_add", 256'(bus.dout_Q_add), 256'(rep(-20)));
      check("lit_Q_sub", 256'(bus.dout_Q_sub), 256'(rep(-80)));
      check("lit_select", 256'(bus.select), 256'(0));

      // Extremes: no wrap in the widened result.
      fill_const(511, 0);  step(1, 0, 0);
      fill_const(511, 0);  step(1, 0, 0);
      check("lit_max_add", 256'(bus.dout_R_add), 256'(rep(1022)));
      fill_const(-512, -512); step(1, 0, 0);
      fill_const(511, 511);   step(1, 0, 0);
      check("lit_min_sub", 256'(bus.dout_R_sub), 256'(rep(-1023)));
      check("lit_q_sub",   256'(bus.dout_Q_sub), 256'(rep(-1023)));

      // 18 back-to-back pairs, sof on the very first beat only.
      pulses = 0;
      for (int k = 0; k < 18; k++) begin
         fill_rand(); step(1, k == 0, 0);
         if (bus.dout_valid) pulses++;
         fill_rand(); step(1, 0, 0);
         if (bus.dout_valid) pulses++;
         check("seq_select", 256'(bus.select), 256'(k % 8));
      end
      check("seq_pulses", 256'(pulses), 256'(18));

      // Gaps between x and y, then idle hold.
      fill_const(100, -50); step(1, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 0);
      fill_const(20, 30); step(1, 0, 0);
      check("gap_R_add", 256'(bus.dout_R_add), 256'(rep(120)));
      step(0, 0, 0); step(0, 0, 0);
      check("hold_Q_sub", 256'(bus.dout_Q_sub), 256'(rep(-80)));

      // Frame start while a first beat is pending.
      fill_rand(); step(1, 0, 0);
      fill_const(7, 3); step(1, 1, 0);
      check("sof_err", 256'(bus.sync_err), 256'(1));
      check("sof_novalid", 256'(bus.dout_valid), 256'(0));
      fill_const(1, 2); step(1, 0, 0);
      check("sof_select", 256'(bus.select), 256'(0));
      check("sof_R_add", 256'(bus.dout_R_add), 256'(rep(8)));
      check("sof_err_gone", 256'(bus.sync_err), 256'(0));

      // Reset between x and y.
      fill_rand(); step(1, 0, 0);
      fill_rand(); step(1, 0, 0);
      fill_rand(); step(1, 0, 0);
      step(0, 0, 1);
      check("rst_R_add", 256'(bus.dout_R_add), 256'(rep(0)));
      check("rst_select", 256'(bus.select), 256'(0));
      fill_const(-3, 4); step(1, 0, 0);
      fill_const(5, -6); step(1, 0, 0);
      check("rst_pair_valid", 256'(bus.dout_valid), 256'(1));
      check("rst_pair_select", 256'(bus.select), 256'(0));
      check("rst_pair_R_sub", 256'(bus.dout_R_sub), 256'(rep(-8)));

      // Randomized traffic.
      for (int k = 0; k < 600; k++) begin
         fill_rand();
         step($urandom_range(99) < 70, $urandom_range(99) < 5, $urandom_range(199) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
